// File: rtl/life_pkg.sv
// Shared definitions for the life-stage FSM and its stepper: stage codes,
// stepper states and error classifications.
package life_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } stage_e;

  typedef enum logic [2:0] {
    IDLE,
    DWELL,
    PULSE,
    WAIT_ACK,
    DONE,
    ERROR
  } stepper_state_e;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_BAD_START  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;
  localparam logic [1:0] ERR_UNEXPECTED = 2'b11;

endpackage

// File: rtl/life_stepper_if.sv
// Advance/stage-report interface between the stepper (master) and the
// environment that controls it and hosts the life FSM (slave).
interface life_stepper_if;

  logic       start;
  logic       pause;
  logic       clear;
  logic [2:0] state_in;
  logic       advance;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [2:0] expected;

  modport master (
    input  start, pause, clear, state_in,
    output advance, busy, done, error, err_code, expected
  );

  modport slave (
    output start, pause, clear, state_in,
    input  advance, busy, done, error, err_code, expected
  );

endinterface

// File: rtl/life_dwell_timer.sv
// Loadable down-counter shared by the dwell period and the ack timeout;
// load has priority over enable and the count saturates at zero.
module life_dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/life_stepper.sv
// Walks the life-stage FSM from S0 to LAST_STAGE with timed advance pulses,
// verifying each stage change and classifying any failure.
module life_stepper
  import life_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int TIMEOUT      = 4,
  parameter int LAST_STAGE   = 5,
  parameter int CNT_W        = 16
) (
  input logic           clk,
  input logic           reset_n,
  life_stepper_if.master bus
);

  localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       LAST_CODE    = 3'(LAST_STAGE);

  stepper_state_e   state_q, state_d;
  logic [2:0]       expected_q, expected_d;
  logic [1:0]       errCode_q, errCode_d;
  logic             advance_q, busy_q, done_q, error_q;

  logic             timerLoad;
  logic [CNT_W-1:0] timerLoadVal;
  logic             timerEn;
  logic             timerZero;

  life_dwell_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timerLoad),
    .load_val_i (timerLoadVal),
    .en_i       (timerEn),
    .zero_o     (timerZero)
  );

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    errCode_d    = errCode_q;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    timerEn      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.state_in == S0) begin
            state_d      = DWELL;
            timerLoad    = 1'b1;
            timerLoadVal = DWELL_LOAD;
          end else begin
            state_d   = ERROR;
            errCode_d = ERR_BAD_START;
          end
        end
      end

      // A stage change we did not ask for outranks pause and the dwell count.
      DWELL: begin
        if (bus.state_in != expected_q) begin
          state_d   = ERROR;
          errCode_d = ERR_UNEXPECTED;
        end else if (!bus.pause) begin
          if (timerZero) begin
            state_d = PULSE;
          end else begin
            timerEn = 1'b1;
          end
        end
      end

      PULSE: begin
        state_d      = WAIT_ACK;
        expected_d   = expected_q + 3'd1;
        timerLoad    = 1'b1;
        timerLoadVal = TIMEOUT_LOAD;
      end

      // Still reporting the previous stage means "not yet"; anything else is wrong.
      WAIT_ACK: begin
        if (bus.state_in == expected_q) begin
          if (expected_q == LAST_CODE) begin
            state_d = DONE;
          end else begin
            state_d      = DWELL;
            timerLoad    = 1'b1;
            timerLoadVal = DWELL_LOAD;
          end
        end else if (bus.state_in == (expected_q - 3'd1)) begin
          if (timerZero) begin
            state_d   = ERROR;
            errCode_d = ERR_TIMEOUT;
          end else begin
            timerEn = 1'b1;
          end
        end else begin
          state_d   = ERROR;
          errCode_d = ERR_UNEXPECTED;
        end
      end

      DONE, ERROR: begin
        if (bus.clear) begin
          state_d    = IDLE;
          expected_d = 3'd0;
          errCode_d  = ERR_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      expected_q <= 3'd0;
      errCode_q  <= ERR_NONE;
      advance_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      errCode_q  <= errCode_d;
      advance_q  <= (state_d == PULSE);
      busy_q     <= (state_d == DWELL) || (state_d == PULSE) || (state_d == WAIT_ACK);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERROR);
    end
  end

  assign bus.advance  = advance_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = errCode_q;
  assign bus.expected = expected_q;

endmodule

// File: tb/tb_life_stepper.sv
// Self-checking bench for life_stepper: a small life FSM model answers the
// advance pulses; vectors and directed sequences cover timing and error paths.
module tb_life_stepper;
  import life_pkg::*;

  typedef struct {
    logic [2:0] stateIn;
    logic       expBusy;
    logic       expError;
    logic [1:0] expCode;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] fsmStage;
  logic [2:0] fsmLimit;
  logic       overrideEn;
  logic [2:0] overrideVal;

  int vecCount  = 0;
  int missCount = 0;
  int pulseAt[8];
  int pulseCount;
  int doneAt;
  int errorAt;

  vec_t vecs[8];

  always #5 clk = ~clk;

  life_stepper_if bus();

  life_stepper #(
    .DWELL_CYCLES(8),
    .TIMEOUT     (4),
    .LAST_STAGE  (5),
    .CNT_W       (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Life FSM model: steps one stage per advance pulse, capped at fsmLimit.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsmStage <= 3'd0;
    end else if (bus.advance && (fsmStage < fsmLimit)) begin
      fsmStage <= fsmStage + 3'd1;
    end
  end

  assign bus.state_in = overrideEn ? overrideVal : fsmStage;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    vecCount++;
    if (actual != required) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic doReset();
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.clear   = 1'b0;
    overrideEn  = 1'b0;
    overrideVal = 3'd0;
    fsmLimit    = 3'd5;
    reset_n     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Starts a run and logs when pulses, done and error first appear (ticks after start).
  task automatic runAndRecord(input int pauseAt, input int pauseLen, input int maxTicks);
    pulseCount = 0;
    doneAt     = -1;
    errorAt    = -1;
    for (int i = 0; i < 8; i++) pulseAt[i] = -1;
    bus.start = 1'b1;
    for (int t = 1; t <= maxTicks; t++) begin
      tick();
      bus.start = 1'b0;
      if (bus.advance) begin
        if (pulseCount < 8) pulseAt[pulseCount] = t;
        pulseCount++;
      end
      if (bus.done && doneAt < 0) doneAt = t;
      if (bus.error && errorAt < 0) errorAt = t;
      bus.pause = (t >= pauseAt) && (t < pauseAt + pauseLen);
      if (doneAt >= 0 || errorAt >= 0) break;
    end
    bus.pause = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    doReset();
    overrideEn  = 1'b1;
    overrideVal = v.stateIn;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput($sformatf("vec%0d busy", idx), int'(bus.busy), int'(v.expBusy));
    checkOutput($sformatf("vec%0d error", idx), int'(bus.error), int'(v.expError));
    checkOutput($sformatf("vec%0d err_code", idx), int'(bus.err_code), int'(v.expCode));
    checkOutput($sformatf("vec%0d advance", idx), int'(bus.advance), 0);
    if (v.expError) begin
      tick();
      checkOutput($sformatf("vec%0d error held", idx), int'(bus.error), 1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      checkOutput($sformatf("vec%0d cleared error", idx), int'(bus.error), 0);
      checkOutput($sformatf("vec%0d cleared code", idx), int'(bus.err_code), 0);
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b1, 1'b0, 2'b00};
    vecs[1] = '{3'd1, 1'b0, 1'b1, 2'b01};
    vecs[2] = '{3'd2, 1'b0, 1'b1, 2'b01};
    vecs[3] = '{3'd3, 1'b0, 1'b1, 2'b01};
    vecs[4] = '{3'd4, 1'b0, 1'b1, 2'b01};
    vecs[5] = '{3'd5, 1'b0, 1'b1, 2'b01};
    vecs[6] = '{3'd6, 1'b0, 1'b1, 2'b01};
    vecs[7] = '{3'd7, 1'b0, 1'b1, 2'b01};

    doReset();
    checkOutput("reset advance", int'(bus.advance), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset done", int'(bus.done), 0);
    checkOutput("reset error", int'(bus.error), 0);
    checkOutput("reset err_code", int'(bus.err_code), 0);
    checkOutput("reset expected", int'(bus.expected), 0);

    $display("[TB] full run with attached FSM");
    runAndRecord(-100, 0, 120);
    checkOutput("run pulse count", pulseCount, 5);
    checkOutput("run first pulse", pulseAt[0], 9);
    for (int i = 1; i < 5; i++)
      checkOutput($sformatf("run spacing %0d", i), pulseAt[i] - pulseAt[i-1], 10);
    checkOutput("run done tick", doneAt, 51);
    checkOutput("run error tick", errorAt, -1);
    checkOutput("run expected", int'(bus.expected), 5);
    checkOutput("run busy", int'(bus.busy), 0);

    $display("[TB] start and clear together in DONE");
    bus.start = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checkOutput("clr+start done", int'(bus.done), 0);
    checkOutput("clr+start busy", int'(bus.busy), 0);
    checkOutput("clr+start expected", int'(bus.expected), 0);
    tick();
    bus.start = 1'b0;
    checkOutput("restart sees stage 5 error", int'(bus.error), 1);
    checkOutput("restart code", int'(bus.err_code), 1);

    $display("[TB] pause during stage 2 dwell");
    doReset();
    runAndRecord(24, 6, 120);
    checkOutput("pause pulse count", pulseCount, 5);
    checkOutput("pause pulse1", pulseAt[1], 19);
    checkOutput("pause pulse2", pulseAt[2], 35);
    checkOutput("pause pulse3", pulseAt[3], 45);
    checkOutput("pause done tick", doneAt, 57);

    $display("[TB] ack timeout with stage stuck at 1");
    doReset();
    fsmLimit = 3'd1;
    runAndRecord(-100, 0, 80);
    checkOutput("timeout pulse count", pulseCount, 2);
    checkOutput("timeout pulse2", pulseAt[1], 19);
    checkOutput("timeout error tick", errorAt, 24);
    checkOutput("timeout err_code", int'(bus.err_code), 2);
    checkOutput("timeout busy", int'(bus.busy), 0);

    $display("[TB] unexpected stage during dwell");
    doReset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checkOutput("dwell busy", int'(bus.busy), 1);
    overrideEn  = 1'b1;
    overrideVal = 3'd3;
    tick();
    checkOutput("unexpected error", int'(bus.error), 1);
    checkOutput("unexpected code", int'(bus.err_code), 3);
    checkOutput("unexpected busy", int'(bus.busy), 0);

    $display("[TB] start-stage vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("[TB] async reset during PULSE");
    doReset();
    bus.start = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      bus.start = 1'b0;
    end
    checkOutput("pulse before reset", int'(bus.advance), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset advance", int'(bus.advance), 0);
    checkOutput("async reset busy", int'(bus.busy), 0);
    checkOutput("async reset expected", int'(bus.expected), 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("after reset advance", int'(bus.advance), 0);
    checkOutput("after reset busy", int'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
